// File: rtl/muldiv_pkg.sv
// Shared types and defaults for the sequential multiply controller.
package muldiv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_FIXUP  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    localparam int TIMEOUT_DEFAULT = 48;

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Signal bundle between the pipeline/multiplier environment and mul_seq_ctrl.
// Handshakes are single-cycle pulses, no backpressure: start/abort/result_valid from the
// controller, done from the multiplier (product valid only while done=1); stall is level.
interface mul_seq_ctrl_if
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) ();
    logic              mul_use;
    logic [1:0]        mul_opcode;
    logic [XLEN-1:0]   operand1;
    logic [XLEN-1:0]   operand2;
    logic              flush;
    logic              start;
    logic [XLEN-1:0]   mul_a;
    logic [XLEN-1:0]   mul_b;
    logic              abort;
    logic              done;
    logic [2*XLEN-1:0] product;
    logic              stall;
    logic              result_valid;
    logic [XLEN-1:0]   result_m;
    logic              timeout_err;
    state_e            dbg_state;

    modport slave (
        input  mul_use, mul_opcode, operand1, operand2, flush, done, product,
        output start, mul_a, mul_b, abort, stall, result_valid, result_m, timeout_err,
        output dbg_state
    );

    modport master (
        output mul_use, mul_opcode, operand1, operand2, flush, done, product,
        input  start, mul_a, mul_b, abort, stall, result_valid, result_m, timeout_err,
        input  dbg_state
    );
endinterface

// File: rtl/mul_seq_ctrl_fixup.sv
// Combinational sign restore and high/low half select of the unsigned product.
module mul_sign_fixup #(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] product_i,
    input  logic              negate_i,
    input  logic              sel_hi_i,
    output logic [XLEN-1:0]   result_o
);
    logic [2*XLEN-1:0] signed_prod;

    always_comb begin
        signed_prod = negate_i ? (~product_i + 1'b1) : product_i;
        result_o    = sel_hi_i ? signed_prod[2*XLEN-1:XLEN] : signed_prod[XLEN-1:0];
    end
endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequences one M-extension multiply through an external iterative unsigned multiplier.
module mul_seq_ctrl
    import muldiv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input logic           clk,
    input logic           rst,
    mul_seq_ctrl_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT) + 1;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    mul_op_e           op_q, op_d;
    logic              neg1_q, neg1_d, neg2_q, neg2_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              err_q, err_d;

    logic              in_neg1, in_neg2, fix_negate, fix_sel_hi;
    logic [XLEN-1:0]   fix_res;
    mul_op_e           in_op;

    assign in_op      = mul_op_e'(bus.mul_opcode);
    assign in_neg1    = bus.operand1[XLEN-1] && (in_op == OP_MULH || in_op == OP_MULHSU);
    assign in_neg2    = bus.operand2[XLEN-1] && (in_op == OP_MULH);
    assign fix_negate = (neg1_q ^ neg2_q) && (op_q == OP_MULH || op_q == OP_MULHSU);
    assign fix_sel_hi = (op_q != OP_MUL);

    mul_sign_fixup #(.XLEN(XLEN)) u_fixup (
        .product_i (prod_q),
        .negate_i  (fix_negate),
        .sel_hi_i  (fix_sel_hi),
        .result_o  (fix_res)
    );

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        op_d             = op_q;
        neg1_d           = neg1_q;
        neg2_d           = neg2_q;
        a_d              = a_q;
        b_d              = b_q;
        prod_d           = prod_q;
        res_d            = res_q;
        err_d            = err_q;
        bus.start        = 1'b0;
        bus.abort        = 1'b0;
        bus.stall        = 1'b0;
        bus.result_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.mul_use && !bus.flush) begin
                    bus.stall = 1'b1;
                    op_d      = in_op;
                    neg1_d    = in_neg1;
                    neg2_d    = in_neg2;
                    a_d       = in_neg1 ? -bus.operand1 : bus.operand1;
                    b_d       = in_neg2 ? -bus.operand2 : bus.operand2;
                    if (bus.operand1 == '0 || bus.operand2 == '0) begin
                        res_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                bus.stall = 1'b1;
                if (bus.flush) begin
                    bus.abort = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    bus.start = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                bus.stall = 1'b1;
                // Flush outranks a coincident done so a killed op never retires.
                if (bus.flush) begin
                    bus.abort = 1'b1;
                    state_d   = ST_IDLE;
                end else if (bus.done) begin
                    prod_d  = bus.product;
                    state_d = ST_FIXUP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d     = 1'b1;
                    bus.abort = 1'b1;
                    res_d     = '0;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FIXUP: begin
                bus.stall = 1'b1;
                if (bus.flush) begin
                    bus.abort = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    res_d   = fix_res;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.result_valid = 1'b1;
                state_d          = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // The multiplier shares rst, so no abort or strobe is emitted while in reset.
        if (rst) begin
            bus.start        = 1'b0;
            bus.abort        = 1'b0;
            bus.stall        = 1'b0;
            bus.result_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MUL;
            neg1_q  <= 1'b0;
            neg2_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg1_q  <= neg1_d;
            neg2_q  <= neg2_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    assign bus.mul_a       = a_q;
    assign bus.mul_b       = b_q;
    assign bus.result_m    = res_q;
    assign bus.timeout_err = err_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl with a fixed 32-cycle model multiplier.
module tb_mul_seq_ctrl;
    import muldiv_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;

    mul_seq_ctrl_if #(.XLEN(32)) bus ();

    mul_seq_ctrl #(.XLEN(32), .TIMEOUT(48)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model multiplier: done exactly 32 cycles after start, ignores abort
    logic        m_busy;
    int          m_cnt;
    logic [63:0] m_prod;
    logic        m_hang;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end else if (bus.start) begin
            m_busy <= 1'b1;
            m_cnt  <= 0;
            m_prod <= {32'b0, bus.mul_a} * {32'b0, bus.mul_b};
        end else if (m_busy) begin
            if (m_cnt == 31) m_busy <= 1'b0;
            else             m_cnt  <= m_cnt + 1;
        end
    end

    assign bus.done    = m_busy && (m_cnt == 31) && !m_hang;
    assign bus.product = bus.done ? m_prod : 64'h0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver: issue one multiply, then observe until result_valid (bounded)
    task automatic do_op(input logic [1:0] opc, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int stall_n, output int starts,
                         output int abort_at, output logic [31:0] ma, output logic [31:0] mb,
                         output logic [31:0] res);
        bit got_rv;
        @(posedge clk); #1;
        bus.mul_use    = 1'b1;
        bus.mul_opcode = opc;
        bus.operand1   = a;
        bus.operand2   = b;
        #1;
        check("accept_stall", {63'b0, bus.stall}, 64'd1);
        lat = 0; stall_n = 0; starts = 0; abort_at = -1; ma = '0; mb = '0; res = '0;
        got_rv = 1'b0;
        @(posedge clk); #1;
        bus.mul_use = 1'b0;
        #1;
        lat = 1;
        for (int i = 0; i < 200; i++) begin
            if (bus.start) begin
                starts++;
                ma = bus.mul_a;
                mb = bus.mul_b;
            end
            if (bus.abort) abort_at = lat;
            if (bus.result_valid) begin
                res    = bus.result_m;
                got_rv = 1'b1;
                check("rv_stall_low", {63'b0, bus.stall}, 64'd0);
                break;
            end
            if (bus.stall) stall_n++;
            @(posedge clk); #2;
            lat++;
        end
        if (!got_rv) check("rv_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", {61'b0, bus.dbg_state}, {61'b0, ST_IDLE});
        check("rst_outs", {58'b0, bus.start, bus.abort, bus.stall, bus.result_valid,
                           bus.timeout_err, 1'b0}, 64'd0);
        check("rst_result", {32'b0, bus.result_m}, 64'd0);
        check("rst_mags", {bus.mul_a, bus.mul_b}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    int          lat, stall_n, starts, abort_at, rv_n, done_n;
    logic [31:0] ma, mb, res;

    initial begin
        n_checks = 0; n_err = 0; m_hang = 1'b0;
        bus.mul_use = 1'b0; bus.mul_opcode = 2'b00; bus.operand1 = '0; bus.operand2 = '0;
        bus.flush = 1'b0;
        rst = 1'b1;
        do_reset();

        // MUL 7 x 6
        do_op(2'b00, 32'd7, 32'd6, lat, stall_n, starts, abort_at, ma, mb, res);
        check("mul_res", {32'b0, res}, 64'h2A);
        check("mul_lat", lat, 35);
        check("mul_stall_n", stall_n, 34);
        check("mul_starts", starts, 1);
        @(posedge clk); #1;
        check("mul_hold", {32'b0, bus.result_m}, 64'h2A);

        // MULH -3 x 5
        do_op(2'b01, 32'hFFFF_FFFD, 32'd5, lat, stall_n, starts, abort_at, ma, mb, res);
        check("mulh_mag", {ma, mb}, {32'd3, 32'd5});
        check("mulh_res", {32'b0, res}, 64'hFFFF_FFFF);

        // MULHU all-ones squared
        do_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, stall_n, starts, abort_at, ma, mb, res);
        check("mulhu_res", {32'b0, res}, 64'hFFFF_FFFE);

        // MULHSU -1 x 2
        do_op(2'b10, 32'hFFFF_FFFF, 32'd2, lat, stall_n, starts, abort_at, ma, mb, res);
        check("mulhsu_mag", {ma, mb}, {32'd1, 32'd2});
        check("mulhsu_res", {32'b0, res}, 64'hFFFF_FFFF);

        // zero shortcut
        do_op(2'b00, 32'd0, 32'h1234, lat, stall_n, starts, abort_at, ma, mb, res);
        check("zero_starts", starts, 0);
        check("zero_lat", lat, 1);
        check("zero_res", {32'b0, res}, 64'd0);

        // refresh result_m to a known nonzero value before the flush case
        do_op(2'b00, 32'd7, 32'd6, lat, stall_n, starts, abort_at, ma, mb, res);
        check("mul2_res", {32'b0, res}, 64'h2A);

        // flush while in IDLE blocks acceptance
        @(posedge clk); #1;
        bus.mul_use = 1'b1; bus.flush = 1'b1; bus.operand1 = 32'd3; bus.operand2 = 32'd4;
        #1;
        check("idle_flush_stall", {63'b0, bus.stall}, 64'd0);
        @(posedge clk); #1;
        bus.mul_use = 1'b0; bus.flush = 1'b0;
        #1;
        check("idle_flush_state", {61'b0, bus.dbg_state}, {61'b0, ST_IDLE});

        // flush at WAIT cycle 10
        @(posedge clk); #1;
        bus.mul_use = 1'b1; bus.mul_opcode = 2'b00; bus.operand1 = 32'd3; bus.operand2 = 32'd4;
        @(posedge clk); #1;
        bus.mul_use = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        #1;
        check("flush_in_wait", {61'b0, bus.dbg_state}, {61'b0, ST_WAIT});
        check("flush_abort", {63'b0, bus.abort}, 64'd1);
        check("flush_no_rv", {63'b0, bus.result_valid}, 64'd0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        #1;
        check("flush_stall_low", {63'b0, bus.stall}, 64'd0);
        check("flush_idle", {61'b0, bus.dbg_state}, {61'b0, ST_IDLE});
        rv_n = 0; done_n = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.result_valid) rv_n++;
            if (bus.done) done_n++;
            @(posedge clk); #2;
        end
        check("flush_rv_count", rv_n, 0);
        check("flush_stale_done", done_n, 1);
        check("flush_res_kept", {32'b0, bus.result_m}, 64'h2A);

        // timeout: model never completes
        m_hang = 1'b1;
        do_op(2'b00, 32'd5, 32'd5, lat, stall_n, starts, abort_at, ma, mb, res);
        check("to_abort_at", abort_at, 49);
        check("to_lat", lat, 50);
        check("to_res", {32'b0, res}, 64'd0);
        check("to_err", {63'b0, bus.timeout_err}, 64'd1);
        m_hang = 1'b0;
        do_reset();
        check("to_err_cleared", {63'b0, bus.timeout_err}, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/mul_seq_ctrl.md
MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have the following parameters:
- XLEN, 32: operand and result width.
- TIMEOUT, 48: maximum WAIT cycles before the operation is abandoned.
REQ-003 The block SHALL have the following ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- mul_use  in  1  execute stage holds an M-extension multiply.
- mul_opcode  in  2  funct3[1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- operand1, operand2  in  XLEN  rs1/rs2 values.
- flush  in  1  pipeline flush; kills any operation in flight.
- start  out  1  one-cycle launch pulse to the iterative multiplier.
- mul_a, mul_b  out  XLEN  unsigned magnitudes sent to the multiplier.
- abort  out  1  one-cycle multiplier reset pulse.
- done  in  1  multiplier completion pulse.
- product  in  2*XLEN  unsigned product, valid while done=1.
- stall  out  1  freezes IF/ID/EX.
- result_valid  out  1  one-cycle result strobe.
- result_m  out  XLEN  multiply result.
- timeout_err  out  1  sticky error flag.

Function
REQ-004 The block SHALL implement the states IDLE, LAUNCH, WAIT, FIXUP and DONE.
REQ-005 IDLE, when mul_use=1 and flush=0, SHALL latch the opcode, both operand signs and both magnitudes.
- Signed operands: MULH treats both operands as signed; MULHSU treats operand1 only as signed.
- MUL and MULHU SHALL treat both operands as unsigned.
- Next state: LAUNCH.
REQ-006 Zero shortcut: if either operand is 0 on acceptance, the block SHALL go directly to DONE with result 0 and SHALL NOT issue start.
REQ-007 stall SHALL equal (state in {LAUNCH, WAIT, FIXUP}) or (state==IDLE and mul_use and not flush); it is combinational so the accepting cycle is already stalled.
REQ-008 LAUNCH SHALL assert start for exactly one cycle, then go to WAIT.
REQ-009 mul_a and mul_b SHALL hold their latched magnitudes from LAUNCH until leaving WAIT.
REQ-010 WAIT SHALL increment a cycle counter from 0.
- On done=1: capture product and go to FIXUP.
- If the counter reaches TIMEOUT-1 without done: set timeout_err, pulse abort, go to DONE with result 0.
REQ-011 FIXUP SHALL negate the 64-bit product (two's complement) when the effective operand signs differ and the opcode is not MUL/MULHU.
- It SHALL select bits [31:0] for MUL and [63:32] for the other opcodes.
- Next state: DONE.
REQ-012 DONE SHALL assert result_valid for one cycle with stall=0, then return to IDLE.
REQ-013 result_m SHALL hold its value until the next DONE.
REQ-014 A new mul_use in the DONE cycle SHALL NOT be accepted; it is accepted in the following IDLE cycle.
REQ-015 flush in LAUNCH, WAIT or FIXUP SHALL force IDLE next cycle.
- It SHALL pulse abort and SHALL suppress result_valid.
- result_m SHALL be unchanged.
REQ-016 flush in IDLE SHALL block acceptance.
REQ-017 done in IDLE, LAUNCH or DONE SHALL be ignored (stale completion).
REQ-018 If done and flush coincide in WAIT, flush SHALL win.
REQ-019 Latency from the accept cycle to result_valid SHALL be N+3 cycles, where N is the number of cycles from start to done.

Reset
REQ-020 On rst=1 the block SHALL force IDLE, counter=0, and drive start=0, abort=0, stall=0, result_valid=0, result_m=0, timeout_err=0, mul_a=0, mul_b=0.
REQ-021 rst SHALL have priority over flush and done.
REQ-022 rst mid-operation SHALL NOT emit abort; the multiplier shares rst.

Structure
REQ-023 Package muldiv_pkg SHALL contain:
- the state enum;
- the mul_opcode enum (MUL, MULH, MULHSU, MULHU);
- TIMEOUT_DEFAULT.
REQ-024 One combinational sub-module, mul_sign_fixup, SHALL perform the negation and the hi/lo select; the FSM, counter and registers SHALL remain in mul_seq_ctrl.

Verification
REQ-025 The bench SHALL use a 32-cycle model multiplier and cover these directed scenarios:
- MUL 7 x 6: result_m=0x0000002A; result_valid at accept+35; stall high for 34 cycles.
- MULH 0xFFFFFFFD (-3) x 5: mul_a=3, mul_b=5; result_m=0xFFFFFFFF.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF: result_m=0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2: result_m=0xFFFFFFFF.
- MUL 0 x 0x1234: no start pulse; result_valid one cycle after accept; result_m=0.
- flush at WAIT cycle 10, model done still pulses at cycle 32: abort pulse, no result_valid, stall=0 from the next cycle, result_m unchanged.
- Model never asserts done: timeout_err=1 and abort after TIMEOUT cycles, result_m=0; rst clears timeout_err.
